// File: rtl/ic_fill_ctrl.sv
// Instruction-cache line-fill controller: requests a line on a fetch miss, streams the
// beats into the data array and drains beats of a fill abandoned by a fetch redirect.
// Define IC_FILL_PERF_CNT_EN to add the miss_cnt_o / abort_cnt_o performance counters.
module ic_fill_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [ADDR_WIDTH-1:0]         pc_f_i,
    input  logic                          lookup_hit_i,
    input  logic                          redirect_i,
    output logic                          mem_req_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    input  logic                          mem_gnt_i,
    input  logic                          mem_rvalid_i,
    input  logic [31:0]                   mem_rdata_i,
    output logic                          fill_we_o,
    output logic [$clog2(LINE_WORDS)-1:0] fill_idx_o,
    output logic [31:0]                   fill_data_o,
    output logic                          fill_done_o,
`ifdef IC_FILL_PERF_CNT_EN
    output logic [31:0]                   miss_cnt_o,
    output logic [31:0]                   abort_cnt_o,
`endif
    output logic                          instr_hit_f_o,
    output logic                          ic_repl_permit_o
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = IDX_W + 2;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF_W) - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        FILL  = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   line_addr_q;
    logic [IDX_W-1:0]        cnt_q;
    logic [IDX_W-1:0]        cnt_d;
    logic                    mem_req_q;
    logic                    fill_done_q;
    logic                    permit_q;
    logic                    last_beat;
`ifdef IC_FILL_PERF_CNT_EN
    logic [31:0]             miss_cnt_q;
    logic [31:0]             abort_cnt_q;
`endif

    assign cnt_d     = cnt_q + 1'b1;
    assign last_beat = mem_rvalid_i && (cnt_q == LAST_IDX);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            line_addr_q <= '0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            fill_done_q <= 1'b0;
            permit_q    <= 1'b1;
`ifdef IC_FILL_PERF_CNT_EN
            miss_cnt_q  <= '0;
            abort_cnt_q <= '0;
`endif
        end else begin
            fill_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A miss seen together with a redirect is on the wrong path.
                    if (!lookup_hit_i && !redirect_i) begin
                        state_q     <= REQ;
                        line_addr_q <= pc_f_i & ~OFF_MASK;
                        mem_req_q   <= 1'b1;
                        permit_q    <= 1'b0;
`ifdef IC_FILL_PERF_CNT_EN
                        miss_cnt_q  <= miss_cnt_q + 32'd1;
`endif
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        cnt_q     <= '0;
                        mem_req_q <= 1'b0;
                        if (redirect_i) begin
                            state_q <= ABORT;
`ifdef IC_FILL_PERF_CNT_EN
                            abort_cnt_q <= abort_cnt_q + 32'd1;
`endif
                        end else begin
                            state_q <= FILL;
                        end
                    end else if (redirect_i) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        permit_q  <= 1'b1;
                    end
                end
                FILL: begin
                    if (mem_rvalid_i) begin
                        cnt_q <= cnt_d;
                    end
                    // A redirect on the final beat still leaves a complete line, so finish it.
                    if (last_beat) begin
                        state_q     <= DONE;
                        fill_done_q <= 1'b1;
                    end else if (redirect_i) begin
                        state_q <= ABORT;
`ifdef IC_FILL_PERF_CNT_EN
                        abort_cnt_q <= abort_cnt_q + 32'd1;
`endif
                    end
                end
                ABORT: begin
                    if (mem_rvalid_i) begin
                        cnt_q <= cnt_d;
                    end
                    if (last_beat) begin
                        state_q  <= IDLE;
                        permit_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q  <= IDLE;
                    permit_q <= 1'b1;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                    permit_q  <= 1'b1;
                end
            endcase
        end
    end

    // permit_q is high exactly in IDLE, so it doubles as the hit-forwarding gate.
    assign instr_hit_f_o    = permit_q & lookup_hit_i;
    assign ic_repl_permit_o = permit_q;
    assign mem_req_o        = mem_req_q;
    assign mem_addr_o       = line_addr_q;
    assign fill_we_o        = (state_q == FILL) & mem_rvalid_i;
    assign fill_idx_o       = cnt_q;
    assign fill_data_o      = mem_rdata_i;
    assign fill_done_o      = fill_done_q;
`ifdef IC_FILL_PERF_CNT_EN
    assign miss_cnt_o       = miss_cnt_q;
    assign abort_cnt_o      = abort_cnt_q;
`endif

endmodule

// File: tb/tb_ic_fill_ctrl.sv
// Directed bench for ic_fill_ctrl: normal fill, grant stall, redirects in IDLE/REQ/FILL,
// mid-fill reset and (with IC_FILL_PERF_CNT_EN) the performance counters.
module tb_ic_fill_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [31:0] pc_f_i;
    logic        lookup_hit_i;
    logic        redirect_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        fill_we_o;
    logic [1:0]  fill_idx_o;
    logic [31:0] fill_data_o;
    logic        fill_done_o;
    logic        instr_hit_f_o;
    logic        ic_repl_permit_o;
`ifdef IC_FILL_PERF_CNT_EN
    logic [31:0] miss_cnt_o;
    logic [31:0] abort_cnt_o;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk_i = ~clk_i;

    ic_fill_ctrl #(.LINE_WORDS(4), .ADDR_WIDTH(32)) dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .pc_f_i           (pc_f_i),
        .lookup_hit_i     (lookup_hit_i),
        .redirect_i       (redirect_i),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_gnt_i        (mem_gnt_i),
        .mem_rvalid_i     (mem_rvalid_i),
        .mem_rdata_i      (mem_rdata_i),
        .fill_we_o        (fill_we_o),
        .fill_idx_o       (fill_idx_o),
        .fill_data_o      (fill_data_o),
        .fill_done_o      (fill_done_o),
`ifdef IC_FILL_PERF_CNT_EN
        .miss_cnt_o       (miss_cnt_o),
        .abort_cnt_o      (abort_cnt_o),
`endif
        .instr_hit_f_o    (instr_hit_f_o),
        .ic_repl_permit_o (ic_repl_permit_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h (t=%0t)", tag, obs, $time);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, then settle before checks.
    task automatic cyc(input logic hit, input logic redir, input logic gnt,
                       input logic rv, input logic [31:0] d);
        @(negedge clk_i);
        lookup_hit_i = hit;
        redirect_i   = redir;
        mem_gnt_i    = gnt;
        mem_rvalid_i = rv;
        mem_rdata_i  = d;
        #1;
    endtask

    task automatic do_miss(input logic [31:0] a, input logic ab);
        pc_f_i = a;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, ab, 1'b1, 1'b0, 32'h0);
        check_eq("dm_req", {31'h0, mem_req_o}, 32'h1);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
            check_eq("dm_we", {31'h0, fill_we_o}, {31'h0, ~ab});
        end
        if (!ab) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            check_eq("dm_done", {31'h0, fill_done_o}, 32'h1);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("dm_idle_permit", {31'h0, ic_repl_permit_o}, 32'h1);
        check_eq("dm_idle_done", {31'h0, fill_done_o}, 32'h0);
    endtask

    initial begin
        reset_n_i    = 1'b0;
        pc_f_i       = 32'h0;
        lookup_hit_i = 1'b1;
        redirect_i   = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        repeat (2) @(negedge clk_i);
        #1;
        check_eq("rst_permit", {31'h0, ic_repl_permit_o}, 32'h1);
        check_eq("rst_hit_pass", {31'h0, instr_hit_f_o}, 32'h1);
        check_eq("rst_req", {31'h0, mem_req_o}, 32'h0);
        check_eq("rst_addr", mem_addr_o, 32'h0);
        check_eq("rst_done", {31'h0, fill_done_o}, 32'h0);
        check_eq("rst_idx", {30'h0, fill_idx_o}, 32'h0);
`ifdef IC_FILL_PERF_CNT_EN
        check_eq("rst_miss_cnt", miss_cnt_o, 32'h0);
        check_eq("rst_abort_cnt", abort_cnt_o, 32'h0);
`endif
        @(negedge clk_i);
        reset_n_i = 1'b1;

        // Basic fill: miss at 0x1234, zero-wait memory, hit seven cycles later.
        pc_f_i = 32'h0000_1234;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("s1_miss_hit", {31'h0, instr_hit_f_o}, 32'h0);
        check_eq("s1_miss_permit", {31'h0, ic_repl_permit_o}, 32'h1);
        check_eq("s1_miss_req", {31'h0, mem_req_o}, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("s1_req", {31'h0, mem_req_o}, 32'h1);
        check_eq("s1_addr", mem_addr_o, 32'h0000_1230);
        check_eq("s1_req_permit", {31'h0, ic_repl_permit_o}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hA0 + k);
            check_eq("s1_we", {31'h0, fill_we_o}, 32'h1);
            check_eq("s1_idx", {30'h0, fill_idx_o}, k);
            check_eq("s1_data", fill_data_o, 32'hA0 + k);
            check_eq("s1_nodone", {31'h0, fill_done_o}, 32'h0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("s1_done", {31'h0, fill_done_o}, 32'h1);
        check_eq("s1_done_we", {31'h0, fill_we_o}, 32'h0);
        check_eq("s1_done_permit", {31'h0, ic_repl_permit_o}, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("s1_hit", {31'h0, instr_hit_f_o}, 32'h1);
        check_eq("s1_done_pulse", {31'h0, fill_done_o}, 32'h0);
        check_eq("s1_permit", {31'h0, ic_repl_permit_o}, 32'h1);

        // Grant withheld five cycles: request and address stay put, fetch stalls.
        pc_f_i = 32'h0000_ABCD;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            check_eq("s2_req", {31'h0, mem_req_o}, 32'h1);
            check_eq("s2_addr", mem_addr_o, 32'h0000_ABC0);
            check_eq("s2_stall", {31'h0, instr_hit_f_o}, 32'h0);
        end
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("s2_done", {31'h0, fill_done_o}, 32'h1);

        // Miss coinciding with a redirect is dropped.
        pc_f_i = 32'h0000_5000;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("s3_drop_req", {31'h0, mem_req_o}, 32'h0);
        check_eq("s3_drop_permit", {31'h0, ic_repl_permit_o}, 32'h1);

        // Redirect while waiting for grant: request withdrawn, stray beat ignored.
        pc_f_i = 32'h0000_2000;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("s3_req", {31'h0, mem_req_o}, 32'h1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h5);
        check_eq("s3_req_drop", {31'h0, mem_req_o}, 32'h0);
        check_eq("s3_permit", {31'h0, ic_repl_permit_o}, 32'h1);
        check_eq("s3_stray_we", {31'h0, fill_we_o}, 32'h0);
        check_eq("s3_hit", {31'h0, instr_hit_f_o}, 32'h1);

        // Redirect on beat 1: beats 0..1 written, 2..3 absorbed, no done.
        pc_f_i = 32'h0000_3010;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        check_eq("s4_we0", {31'h0, fill_we_o}, 32'h1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h1);
        check_eq("s4_we1", {31'h0, fill_we_o}, 32'h1);
        check_eq("s4_idx1", {30'h0, fill_idx_o}, 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h2);
        check_eq("s4_we2", {31'h0, fill_we_o}, 32'h0);
        check_eq("s4_abort_permit", {31'h0, ic_repl_permit_o}, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h3);
        check_eq("s4_we3", {31'h0, fill_we_o}, 32'h0);
        check_eq("s4_nodone3", {31'h0, fill_done_o}, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("s4_nodone", {31'h0, fill_done_o}, 32'h0);
        check_eq("s4_idle_permit", {31'h0, ic_repl_permit_o}, 32'h1);
        check_eq("s4_idle_hit", {31'h0, instr_hit_f_o}, 32'h1);

        // Reset arriving with beat 2: immediate IDLE, trailing beat ignored.
        pc_f_i = 32'h0000_4000;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h1);
`ifdef IC_FILL_PERF_CNT_EN
        check_eq("pc_miss_pre", miss_cnt_o, 32'd5);
        check_eq("pc_abort_pre", abort_cnt_o, 32'd1);
`endif
        @(negedge clk_i);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h2;
        reset_n_i    = 1'b0;
        #1;
        check_eq("s5_rst_permit", {31'h0, ic_repl_permit_o}, 32'h1);
        check_eq("s5_rst_we", {31'h0, fill_we_o}, 32'h0);
        check_eq("s5_rst_done", {31'h0, fill_done_o}, 32'h0);
        check_eq("s5_rst_req", {31'h0, mem_req_o}, 32'h0);
        @(negedge clk_i);
        reset_n_i    = 1'b1;
        lookup_hit_i = 1'b1;
        mem_rdata_i  = 32'h3;
        #1;
        check_eq("s5_late_we", {31'h0, fill_we_o}, 32'h0);
        check_eq("s5_late_hit", {31'h0, instr_hit_f_o}, 32'h1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("s5_nodone", {31'h0, fill_done_o}, 32'h0);
        check_eq("s5_permit", {31'h0, ic_repl_permit_o}, 32'h1);

        // Three misses, the middle one aborted at grant.
        do_miss(32'h0000_6000, 1'b0);
        do_miss(32'h0000_6104, 1'b1);
        do_miss(32'h0000_6208, 1'b0);
`ifdef IC_FILL_PERF_CNT_EN
        check_eq("pc_miss_cnt", miss_cnt_o, 32'd3);
        check_eq("pc_abort_cnt", abort_cnt_o, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
